// File: rtl/lu_arbiter.sv
// Two-requester arbiter time-sharing one bitwise OR/NOR unit.
// Each operation takes three cycles: grant (EXEC), result (DONE), then back to IDLE.
module lu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sel0,
  input  logic             sel1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             done_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sel_reg;
  logic             id_reg;
  logic             last_reg;
  logic [WIDTH-1:0] result_reg;
  logic             done_id_reg;
  logic             any_req;
  logic             winner;
  logic             start;
  logic [WIDTH-1:0] lu_out;

  assign any_req = req0 | req1;

  // On a tie the requester not served last wins; otherwise the lone requester wins.
  assign winner = (req0 && req1) ? ~last_reg : req1;

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = EXEC;
          start      = 1'b1;
        end
      end
      EXEC:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lu
      assign lu_out[gi] = sel_reg ? (a_reg[gi] | b_reg[gi]) : ~(a_reg[gi] | b_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      sel_reg     <= 1'b0;
      id_reg      <= 1'b0;
      last_reg    <= 1'b1;
      result_reg  <= '0;
      done_id_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Operands are captured at the grant edge so later input changes cannot disturb the operation.
      if (start) begin
        a_reg   <= winner ? a1 : a0;
        b_reg   <= winner ? b1 : b0;
        sel_reg <= winner ? sel1 : sel0;
        id_reg  <= winner;
      end
      if (state_reg == EXEC) begin
        result_reg  <= lu_out;
        done_id_reg <= id_reg;
        last_reg    <= id_reg;
      end
    end
  end

  assign gnt0    = (state_reg == EXEC) && !id_reg;
  assign gnt1    = (state_reg == EXEC) && id_reg;
  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign result  = result_reg;
  assign done_id = done_id_reg;

endmodule

// File: tb/tb_lu_arbiter.sv
// Directed bench for lu_arbiter: one task per scenario with hand-computed expectations.
module tb_lu_arbiter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             sel0, sel1;
  logic             gnt0, gnt1, busy, done, done_id;
  logic [WIDTH-1:0] result;

  int checks = 0;
  int errors = 0;

  lu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .sel0(sel0), .sel1(sel1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .result(result), .done(done), .done_id(done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0 = 0; req1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; sel0 = 0; sel1 = 0;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (result !== 4'b0000) begin errors++; $display("FAIL reset_result: got %b want 0000", result); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({busy, gnt0, gnt1, done} !== 4'b0000) begin errors++; $display("FAIL idle_outputs cycle %0d: busy/gnt0/gnt1/done got %b want 0000", i, {busy, gnt0, gnt1, done}); end
      checks++; if (result !== 4'b0000) begin errors++; $display("FAIL idle_result cycle %0d: got %b want 0000", i, result); end
    end
    $display("test_reset: %0d checks so far", checks);
  endtask

  task automatic test_req0_or();
    req0 = 1; a0 = 4'b1010; b0 = 4'b0110; sel0 = 1;
    tick();
    checks++; if ({gnt0, gnt1, busy, done} !== 4'b1010) begin errors++; $display("FAIL req0_grant: gnt0/gnt1/busy/done got %b want 1010", {gnt0, gnt1, busy, done}); end
    req0 = 0;
    tick();
    checks++; if ({gnt0, gnt1, busy, done} !== 4'b0011) begin errors++; $display("FAIL req0_done: gnt0/gnt1/busy/done got %b want 0011", {gnt0, gnt1, busy, done}); end
    checks++; if (result !== 4'b1110) begin errors++; $display("FAIL req0_result: got %b want 1110", result); end
    checks++; if (done_id !== 1'b0) begin errors++; $display("FAIL req0_done_id: got %b want 0", done_id); end
    tick();
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL req0_idle: busy/done got %b want 00", {busy, done}); end
    checks++; if (result !== 4'b1110) begin errors++; $display("FAIL req0_hold: got %b want 1110", result); end
    $display("test_req0_or: result=%b done_id=%b", result, done_id);
  endtask

  task automatic test_req1_nor();
    req1 = 1; a1 = 4'b1010; b1 = 4'b0110; sel1 = 0;
    tick();
    checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("FAIL req1_grant: gnt0/gnt1 got %b want 01", {gnt0, gnt1}); end
    req1 = 0;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL req1_done: got %b want 1", done); end
    checks++; if (result !== 4'b0001) begin errors++; $display("FAIL req1_result: got %b want 0001", result); end
    checks++; if (done_id !== 1'b1) begin errors++; $display("FAIL req1_done_id: got %b want 1", done_id); end
    tick();
    checks++; if (done_id !== 1'b1) begin errors++; $display("FAIL req1_id_hold: got %b want 1", done_id); end
    $display("test_req1_nor: result=%b done_id=%b", result, done_id);
  endtask

  task automatic test_round_robin();
    logic [1:0]       exp_gnt;
    logic [WIDTH-1:0] exp_res;
    logic             exp_id;
    a0 = 4'b0011; b0 = 4'b0000; sel0 = 1;
    a1 = 4'b0101; b1 = 4'b0000; sel1 = 1;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      // Last served was requester 1, so the tie sequence starts with requester 0.
      exp_id  = ((i / 3) % 2 == 1);
      exp_gnt = (i % 3 == 0) ? (exp_id ? 2'b01 : 2'b10) : 2'b00;
      if (i == 11) begin req0 = 0; req1 = 0; end
      checks++; if ({gnt0, gnt1} !== exp_gnt) begin errors++; $display("FAIL rr_grant cycle %0d: gnt0/gnt1 got %b want %b", i, {gnt0, gnt1}, exp_gnt); end
      if (i % 3 == 1) begin
        exp_res = exp_id ? 4'b0101 : 4'b0011;
        checks++; if ({done, done_id} !== {1'b1, exp_id}) begin errors++; $display("FAIL rr_done cycle %0d: done/done_id got %b want %b", i, {done, done_id}, {1'b1, exp_id}); end
        checks++; if (result !== exp_res) begin errors++; $display("FAIL rr_result cycle %0d: got %b want %b", i, result, exp_res); end
      end
    end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_settle: busy got %b want 0", busy); end
    $display("test_round_robin: 4 operations, last done_id=%b", done_id);
  endtask

  task automatic test_operand_latch();
    req0 = 1; a0 = 4'b1111; b0 = 4'b0000; sel0 = 0;
    tick();
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL latch_grant: gnt0 got %b want 1", gnt0); end
    req0 = 0; a0 = 4'b0000;
    tick();
    checks++; if ({done, done_id} !== 2'b10) begin errors++; $display("FAIL latch_done: done/done_id got %b want 10", {done, done_id}); end
    checks++; if (result !== 4'b0000) begin errors++; $display("FAIL latch_result: got %b want 0000", result); end
    tick();
    $display("test_operand_latch: result=%b", result);
  endtask

  task automatic test_reset_exec();
    req0 = 1; a0 = 4'b1100; b0 = 4'b0001; sel0 = 1;
    tick();
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rst_exec_grant: gnt0 got %b want 1", gnt0); end
    req0 = 0;
    #2 reset = 1'b1;
    #1;
    checks++; if ({gnt0, busy, done} !== 3'b000) begin errors++; $display("FAIL rst_exec_abort: gnt0/busy/done got %b want 000", {gnt0, busy, done}); end
    #2 reset = 1'b0;
    tick();
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_exec_no_done: busy/done got %b want 00", {busy, done}); end
    checks++; if (result !== 4'b0000) begin errors++; $display("FAIL rst_exec_result: got %b want 0000", result); end
    req0 = 1;
    tick();
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL rst_exec_regrant: gnt0/gnt1 got %b want 10", {gnt0, gnt1}); end
    req0 = 0;
    tick();
    checks++; if ({done, done_id} !== 2'b10) begin errors++; $display("FAIL rst_exec_redone: done/done_id got %b want 10", {done, done_id}); end
    checks++; if (result !== 4'b1101) begin errors++; $display("FAIL rst_exec_reresult: got %b want 1101", result); end
    tick();
    $display("test_reset_exec: result=%b", result);
  endtask

  initial begin
    test_reset();
    test_req0_or();
    test_req1_nor();
    test_round_robin();
    test_operand_latch();
    test_reset_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
